// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic result stage: select codes,
// skid-buffer state encoding and the packed flags word.
package arith_pkg;

    localparam logic [1:0] SEL_ADD   = 2'b00;
    localparam logic [1:0] SEL_SUB   = 2'b01;
    localparam logic [1:0] SEL_SHIFT = 2'b10;
    localparam logic [1:0] SEL_NONE  = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } stage_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } flags_t;

endpackage

// File: rtl/result_flags.sv
// Combinational zero/negative/carry flag generation for one result word.
module result_flags
    import arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] result,
    input  logic         carry,
    input  logic [1:0]   select,
    output flags_t       flags
);

    always_comb begin
        flags   = '0;
        flags.z = (result == '0);
        flags.n = result[N-1];
        // Carry is only meaningful for add; every other operation clears it.
        flags.c = (select == SEL_ADD) ? carry : 1'b0;
    end

endmodule

// File: rtl/arith_result_stage.sv
// Two-entry skid buffer holding arithmetic results and their flags.
// Optional accepted-entry counter enabled by ARITH_STAGE_COUNT_EN.
//   state | meaning
//   EMPTY | no entry held, out_valid low
//   ONE   | main holds the presented entry
//   TWO   | main presented, skid holds the next entry, in_ready low
module arith_result_stage
    import arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] result,
    input  logic         carry,
    input  logic [1:0]   select,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [1:0]   out_select,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c
`ifdef ARITH_STAGE_COUNT_EN
    ,
    output logic [7:0]   op_count
`endif
);

    stage_state_e r_state;
    logic [N-1:0] r_main_result;
    logic [1:0]   r_main_select;
    flags_t       r_main_flags;
    logic [N-1:0] r_skid_result;
    logic [1:0]   r_skid_select;
    flags_t       r_skid_flags;

    flags_t w_in_flags;
    logic   w_push;
    logic   w_pop;

    result_flags #(.N(N)) u_flags (
        .result (result),
        .carry  (carry),
        .select (select),
        .flags  (w_in_flags)
    );

    // Reset gating keeps the stage from advertising space while it is being cleared.
    assign in_ready   = (r_state != TWO) && !reset;
    assign out_valid  = (r_state != EMPTY);
    assign out_result = r_main_result;
    assign out_select = r_main_select;
    assign flag_z     = r_main_flags.z;
    assign flag_n     = r_main_flags.n;
    assign flag_c     = r_main_flags.c;

    assign w_push = in_valid && in_ready && (select != SEL_NONE);
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= EMPTY;
            r_main_result <= '0;
            r_main_select <= '0;
            r_main_flags  <= '0;
            r_skid_result <= '0;
            r_skid_select <= '0;
            r_skid_flags  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state       <= ONE;
                        r_main_result <= result;
                        r_main_select <= select;
                        r_main_flags  <= w_in_flags;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_main_result <= result;
                        r_main_select <= select;
                        r_main_flags  <= w_in_flags;
                    end else if (w_push) begin
                        r_state       <= TWO;
                        r_skid_result <= result;
                        r_skid_select <= select;
                        r_skid_flags  <= w_in_flags;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_state       <= ONE;
                        r_main_result <= r_skid_result;
                        r_main_select <= r_skid_select;
                        r_main_flags  <= r_skid_flags;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef ARITH_STAGE_COUNT_EN
    logic [7:0] r_op_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_push && (r_op_count != 8'hFF)) begin
            r_op_count <= r_op_count + 8'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_arith_result_stage.sv
// Self-checking bench for arith_result_stage (N=4): directed scenarios plus
// random traffic against a queue-based reference model.
module tb_arith_result_stage;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] result;
    logic         carry;
    logic [1:0]   select;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [1:0]   out_select;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
`ifdef ARITH_STAGE_COUNT_EN
    logic [7:0]   op_count;
`endif

    arith_result_stage #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result     (result),
        .carry      (carry),
        .select     (select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_select (out_select),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c)
`ifdef ARITH_STAGE_COUNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int sel;
        int z;
        int n;
        int c;
    } entry_t;

    entry_t q[$];
    int     exp_count = 0;
    int     errors    = 0;
    int     checks    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check({tag, ".out_result"}, 32'(out_result), 32'(q[0].res));
            check({tag, ".out_select"}, 32'(out_select), 32'(q[0].sel));
            check({tag, ".flag_z"}, 32'(flag_z), 32'(q[0].z));
            check({tag, ".flag_n"}, 32'(flag_n), 32'(q[0].n));
            check({tag, ".flag_c"}, 32'(flag_c), 32'(q[0].c));
        end
`ifdef ARITH_STAGE_COUNT_EN
        check({tag, ".op_count"}, 32'(op_count), 32'(exp_count));
`endif
    endtask

    // One clock of traffic: drive, check readiness, advance model, check outputs.
    task automatic step(input string tag, input logic v, input int r, input logic c,
                        input int s, input logic ordy);
        bit     exp_ready;
        bit     push;
        bit     pop;
        entry_t e;
        in_valid  = v;
        result    = N'(r);
        carry     = c;
        select    = 2'(s);
        out_ready = ordy;
        #1;
        exp_ready = (q.size() < 2);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        push = v && exp_ready && (s != 3);
        pop  = (q.size() > 0) && ordy;
        e.res = r;
        e.sel = s;
        e.z   = (r == 0) ? 1 : 0;
        e.n   = (r >= (1 << (N - 1))) ? 1 : 0;
        e.c   = (s == 0) ? int'(c) : 0;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(e);
            if (exp_count < 255) exp_count++;
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, ".in_ready_during_reset"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        exp_count = 0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_result"}, 32'(out_result), 32'd0);
        check({tag, ".out_select"}, 32'(out_select), 32'd0);
        check({tag, ".flags"}, {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        check({tag, ".in_ready_held"}, 32'(in_ready), 32'd0);
`ifdef ARITH_STAGE_COUNT_EN
        check({tag, ".op_count"}, 32'(op_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, ".in_ready_after_release"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        result    = '0;
        carry     = 1'b0;
        select    = 2'b00;
        out_ready = 1'b0;
        @(negedge clk);
        apply_reset("por");

        // Zero result with add carry
        step("zero_add", 1'b1, 0, 1'b1, 0, 1'b0);
        step("zero_pop", 1'b0, 0, 1'b0, 0, 1'b1);

        // Negative subtract, popped while presented
        step("neg_sub", 1'b1, 4'b1010, 1'b1, 1, 1'b1);
        step("neg_sub_pop", 1'b0, 0, 1'b0, 0, 1'b1);

        // Back-pressure: two fill the buffer, the third waits
        step("fill0", 1'b1, 1, 1'b0, 0, 1'b0);
        step("fill1", 1'b1, 2, 1'b1, 2, 1'b0);
        step("fill2_blocked", 1'b1, 3, 1'b1, 0, 1'b0);
        step("fill2_hold", 1'b1, 3, 1'b1, 0, 1'b0);
        step("drain0", 1'b1, 3, 1'b1, 0, 1'b1);
        step("drain1", 1'b0, 0, 1'b0, 0, 1'b1);
        step("drain2", 1'b0, 0, 1'b0, 0, 1'b1);
        step("drain_empty", 1'b0, 0, 1'b0, 0, 1'b1);

        // Discarded operation code
        step("sel_none0", 1'b1, 5, 1'b1, 3, 1'b0);
        step("sel_none1", 1'b1, 0, 1'b1, 3, 1'b1);

        // Reset with both entries held
        step("rst_fill0", 1'b1, 4'hC, 1'b1, 0, 1'b0);
        step("rst_fill1", 1'b1, 4'h7, 1'b0, 1, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        apply_reset("mid_reset");
        step("post_reset_idle", 1'b0, 0, 1'b0, 0, 1'b0);

`ifdef ARITH_STAGE_COUNT_EN
        for (int i = 0; i < 260; i++) begin
            step("count_sat", 1'b1, int'($urandom_range(0, 15)), 1'($urandom),
                 int'($urandom_range(0, 2)), 1'b1);
        end
        check("count_saturated", 32'(op_count), 32'd255);
        step("count_hold", 1'b1, 9, 1'b0, 0, 1'b1);
        check("count_stays", 32'(op_count), 32'd255);
        apply_reset("count_reset");
`endif

        for (int i = 0; i < 400; i++) begin
            step("random", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
